// File: rtl/xocc_dsa_sched.sv
// Shares one DSA engine among NUM_Q XOCC command/response queue pairs.
// Round-robin pop of FWFT command heads, single command in flight, response routed back by qid.
module xocc_dsa_sched #(
  parameter int unsigned NUM_Q        = 2,
  parameter int unsigned CMD_W        = 96,
  parameter int unsigned RSP_W        = 32,
  parameter int unsigned TIMEOUT      = 1024,
  parameter logic [31:0] TIMEOUT_CODE = 32'hDEAD_0000
) (
  input  logic                     dsa_clk,
  input  logic                     dsa_rst,
  input  logic [NUM_Q-1:0]         q_en,
  input  logic [NUM_Q-1:0]         empty_cmd,
  input  logic [NUM_Q*CMD_W-1:0]   dsa_cmd_buffer,
  output logic [NUM_Q-1:0]         rd_en_cmd,
  input  logic [NUM_Q-1:0]         full_rsp,
  output logic [NUM_Q-1:0]         wr_en_rsp,
  output logic [NUM_Q*RSP_W-1:0]   dsa_rsp_buffer,
  output logic                     eng_req_vld,
  input  logic                     eng_req_rdy,
  output logic [CMD_W-1:0]         eng_req_cmd,
  output logic [3:0]               eng_req_qid,
  input  logic                     eng_rsp_vld,
  input  logic [RSP_W-1:0]         eng_rsp_data,
  output logic                     busy,
  output logic                     err_timeout,
  input  logic                     err_clr
);

  localparam int unsigned QW = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, WRITE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [QW-1:0]    rr_ptr;
  logic [QW-1:0]    qid;
  logic [QW-1:0]    cand;
  logic [QW-1:0]    gnt_idx;
  logic             gnt_vld;
  logic [CMD_W-1:0] cmd_sel;
  logic [CMD_W-1:0] cmd_reg;
  logic [RSP_W-1:0] rsp_reg;
  logic [TW-1:0]    timer;
  logic [NUM_Q-1:0] req;
  logic             to_fire;

  assign req     = ~empty_cmd & q_en;
  assign busy    = (state != IDLE);
  // A real response in the same cycle as the deadline always wins.
  assign to_fire = (TIMEOUT != 0) && (state == WAIT_RSP) && !eng_rsp_vld &&
                   (timer == TW'(TIMEOUT - 1));

  // Round-robin search starting just above the last grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    cmd_sel = '0;
    for (int unsigned k = 1; k <= NUM_Q; k++) begin
      cand = QW'((32'(rr_ptr) + k) % NUM_Q);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    for (int unsigned i = 0; i < NUM_Q; i++) begin
      if (gnt_idx == QW'(i)) cmd_sel = dsa_cmd_buffer[i*CMD_W +: CMD_W];
    end
  end

  always_ff @(posedge dsa_clk) begin
    if (dsa_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Strobes are suppressed while reset is held so a dropped command never pushes.
  always_comb begin
    state_nxt      = state;
    rd_en_cmd      = '0;
    wr_en_rsp      = '0;
    dsa_rsp_buffer = '0;
    eng_req_vld    = 1'b0;
    eng_req_cmd    = '0;
    eng_req_qid    = '0;
    if (!dsa_rst) begin
      unique case (state)
        IDLE: begin
          if (gnt_vld) begin
            rd_en_cmd[gnt_idx] = 1'b1;
            state_nxt          = ISSUE;
          end
        end
        ISSUE: begin
          eng_req_vld = 1'b1;
          eng_req_cmd = cmd_reg;
          eng_req_qid = 4'(qid);
          if (eng_req_rdy) state_nxt = WAIT_RSP;
        end
        WAIT_RSP: begin
          if (eng_rsp_vld || to_fire) state_nxt = WRITE;
        end
        WRITE: begin
          for (int unsigned i = 0; i < NUM_Q; i++) begin
            if (qid == QW'(i)) dsa_rsp_buffer[i*RSP_W +: RSP_W] = rsp_reg;
          end
          if (!full_rsp[qid]) begin
            wr_en_rsp[qid] = 1'b1;
            state_nxt      = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge dsa_clk) begin
    if (dsa_rst) begin
      rr_ptr      <= QW'(NUM_Q - 1);
      qid         <= '0;
      cmd_reg     <= '0;
      rsp_reg     <= '0;
      timer       <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == IDLE && gnt_vld) begin
        rr_ptr  <= gnt_idx;
        qid     <= gnt_idx;
        cmd_reg <= cmd_sel;
      end
      if (state == ISSUE)         timer <= '0;
      else if (state == WAIT_RSP) timer <= timer + TW'(1);
      if (state == WAIT_RSP) begin
        if (eng_rsp_vld)  rsp_reg <= eng_rsp_data;
        else if (to_fire) rsp_reg <= RSP_W'(TIMEOUT_CODE);
      end
      if (to_fire)      err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xocc_dsa_sched.sv
// Directed bench for xocc_dsa_sched: two queues, TIMEOUT=16, FIFO heads and engine driven from tables.
module tb_xocc_dsa_sched;

  localparam int unsigned NQ = 2;

  logic            dsa_clk = 1'b0;
  logic            dsa_rst;
  logic [NQ-1:0]   q_en;
  logic [NQ-1:0]   empty_cmd;
  logic [NQ*96-1:0] dsa_cmd_buffer;
  logic [NQ-1:0]   rd_en_cmd;
  logic [NQ-1:0]   full_rsp;
  logic [NQ-1:0]   wr_en_rsp;
  logic [NQ*32-1:0] dsa_rsp_buffer;
  logic            eng_req_vld;
  logic            eng_req_rdy;
  logic [95:0]     eng_req_cmd;
  logic [3:0]      eng_req_qid;
  logic            eng_rsp_vld;
  logic [31:0]     eng_rsp_data;
  logic            busy;
  logic            err_timeout;
  logic            err_clr;

  int          n_chk = 0;
  int          n_err = 0;
  logic [95:0] cmd_tab [NQ][4];
  int          cnt  [NQ];
  int          head [NQ];

  xocc_dsa_sched #(
    .NUM_Q(NQ), .CMD_W(96), .RSP_W(32), .TIMEOUT(16), .TIMEOUT_CODE(32'hDEAD_0000)
  ) dut (
    .dsa_clk(dsa_clk), .dsa_rst(dsa_rst), .q_en(q_en), .empty_cmd(empty_cmd),
    .dsa_cmd_buffer(dsa_cmd_buffer), .rd_en_cmd(rd_en_cmd), .full_rsp(full_rsp),
    .wr_en_rsp(wr_en_rsp), .dsa_rsp_buffer(dsa_rsp_buffer), .eng_req_vld(eng_req_vld),
    .eng_req_rdy(eng_req_rdy), .eng_req_cmd(eng_req_cmd), .eng_req_qid(eng_req_qid),
    .eng_rsp_vld(eng_rsp_vld), .eng_rsp_data(eng_rsp_data), .busy(busy),
    .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 dsa_clk = ~dsa_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge dsa_clk);
  endtask

  // FIFO head model: lane shows the next unread table entry.
  task automatic drive_q();
    for (int q = 0; q < NQ; q++) begin
      if (head[q] < cnt[q]) begin
        empty_cmd[q]              = 1'b0;
        dsa_cmd_buffer[q*96 +: 96] = cmd_tab[q][head[q]];
      end else begin
        empty_cmd[q]              = 1'b1;
        dsa_cmd_buffer[q*96 +: 96] = '0;
      end
    end
  endtask

  task automatic do_reset();
    dsa_rst = 1'b1;
    q_en = 2'b11; full_rsp = '0; eng_req_rdy = 1'b0; eng_rsp_vld = 1'b0;
    eng_rsp_data = '0; err_clr = 1'b0;
    for (int q = 0; q < NQ; q++) begin
      cnt[q] = 0;
      head[q] = 0;
    end
    drive_q();
    tick();
    tick();
    dsa_rst = 1'b0;
  endtask

  // One full transaction from the IDLE grant cycle through the push.
  task automatic txn(input string tag, input int q, input int rdy_low, input int dly,
                     input bit to, input int full_cyc, input bit echo, input logic [31:0] rsp_val);
    logic [95:0]   ecmd;
    logic [31:0]   ersp;
    logic [63:0]   ebuf;
    logic [NQ-1:0] oh;
    int            nwait;
    oh = '0;
    oh[q] = 1'b1;
    drive_q();
    #1;
    chk({tag, " pop"}, 128'(rd_en_cmd), 128'(oh));
    ecmd = cmd_tab[q][head[q]];
    head[q]++;
    ersp = to ? 32'hDEAD_0000 : (echo ? ecmd[31:0] : rsp_val);
    ebuf = 64'(ersp) << (32 * q);
    tick();
    drive_q();
    eng_req_rdy = (rdy_low == 0);
    for (int i = 0; i < rdy_low; i++) begin
      #1;
      chk({tag, " stall vld"}, 128'(eng_req_vld), 128'(1));
      chk({tag, " stall cmd"}, 128'(eng_req_cmd), 128'(ecmd));
      tick();
    end
    eng_req_rdy = 1'b1;
    #1;
    chk({tag, " vld"}, 128'(eng_req_vld), 128'(1));
    chk({tag, " cmd"}, 128'(eng_req_cmd), 128'(ecmd));
    chk({tag, " qid"}, 128'(eng_req_qid), 128'(q));
    tick();
    eng_req_rdy = 1'b0;
    nwait = to ? 16 : dly;
    for (int i = 0; i < nwait; i++) begin
      #1;
      chk({tag, " wait vld"}, 128'(eng_req_vld), 128'(0));
      chk({tag, " wait wr"}, 128'(wr_en_rsp), 128'(0));
      tick();
    end
    if (!to) begin
      eng_rsp_vld  = 1'b1;
      eng_rsp_data = ersp;
      #1;
      chk({tag, " rsp wr"}, 128'(wr_en_rsp), 128'(0));
      tick();
      eng_rsp_vld  = 1'b0;
      eng_rsp_data = '0;
    end
    for (int i = 0; i < full_cyc; i++) begin
      full_rsp[q] = 1'b1;
      #1;
      chk({tag, " full wr"}, 128'(wr_en_rsp), 128'(0));
      chk({tag, " full data"}, 128'(dsa_rsp_buffer), 128'(ebuf));
      tick();
    end
    full_rsp = '0;
    #1;
    chk({tag, " push"}, 128'(wr_en_rsp), 128'(oh));
    chk({tag, " data"}, 128'(dsa_rsp_buffer), 128'(ebuf));
    tick();
    #1;
    chk({tag, " post wr"}, 128'(wr_en_rsp), 128'(0));
    chk({tag, " post busy"}, 128'(busy), 128'(0));
  endtask

  initial begin
    do_reset();
    #1;
    chk("rst busy", 128'(busy), 128'(0));
    chk("rst err", 128'(err_timeout), 128'(0));
    chk("rst rd", 128'(rd_en_cmd), 128'(0));
    chk("rst wr", 128'(wr_en_rsp), 128'(0));
    chk("rst buf", 128'(dsa_rsp_buffer), 128'(0));
    chk("rst vld", 128'(eng_req_vld), 128'(0));
    chk("rst cmd", 128'(eng_req_cmd), 128'(0));
    chk("rst qid", 128'(eng_req_qid), 128'(0));

    // Single command on queue 0, response 3 cycles after issue.
    cnt[0] = 1;
    cmd_tab[0][0] = 96'h1;
    txn("basic", 0, 0, 2, 1'b0, 0, 1'b0, 32'hA5);

    // Both queues full of work: grants must alternate starting at queue 0.
    do_reset();
    for (int q = 0; q < NQ; q++) begin
      cnt[q] = 3;
      for (int j = 0; j < 3; j++)
        cmd_tab[q][j] = {32'(q), 32'hC0DE_0000 + 32'(j), 32'h1000_0000 + 32'(q * 16 + j)};
    end
    for (int j = 0; j < 6; j++) txn("rr", j % 2, 0, 1, 1'b0, 0, 1'b1, 32'h0);

    // Engine backpressure on the request side.
    do_reset();
    cnt[0] = 1;
    cmd_tab[0][0] = 96'hABCD_0000_1111_2222_3333_4444;
    txn("stall", 0, 5, 1, 1'b0, 0, 1'b0, 32'h5A5A_0001);

    // Engine silent: timeout code pushed, sticky flag, then cleared.
    do_reset();
    cnt[0] = 1;
    cmd_tab[0][0] = 96'h77;
    txn("tmo", 0, 0, 0, 1'b1, 0, 1'b0, 32'h0);
    chk("tmo err set", 128'(err_timeout), 128'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    chk("tmo err clr", 128'(err_timeout), 128'(0));

    // Response arriving on the last allowed cycle beats the timeout.
    cnt[1] = 1;
    cmd_tab[1][0] = 96'h88;
    txn("edge", 1, 0, 15, 1'b0, 0, 1'b0, 32'h1234_5678);
    chk("edge err", 128'(err_timeout), 128'(0));

    // Response FIFO full for 4 cycles on queue 1.
    do_reset();
    cnt[1] = 1;
    cmd_tab[1][0] = 96'h99;
    txn("full", 1, 0, 1, 1'b0, 4, 1'b0, 32'hFEED_BEEF);

    // Reset mid-flight drops the command; a late response does nothing.
    do_reset();
    cnt[0] = 1;
    cmd_tab[0][0] = 96'h42;
    drive_q();
    tick();
    head[0]++;
    drive_q();
    eng_req_rdy = 1'b1;
    tick();
    eng_req_rdy = 1'b0;
    #1;
    chk("mid busy", 128'(busy), 128'(1));
    dsa_rst = 1'b1;
    tick();
    dsa_rst = 1'b0;
    #1;
    chk("mid rst busy", 128'(busy), 128'(0));
    chk("mid rst vld", 128'(eng_req_vld), 128'(0));
    chk("mid rst rd", 128'(rd_en_cmd), 128'(0));
    chk("mid rst wr", 128'(wr_en_rsp), 128'(0));
    chk("mid rst buf", 128'(dsa_rsp_buffer), 128'(0));
    eng_rsp_vld  = 1'b1;
    eng_rsp_data = 32'hBAD0_0BAD;
    tick();
    eng_rsp_vld  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("late wr", 128'(wr_en_rsp), 128'(0));
      chk("late busy", 128'(busy), 128'(0));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/xocc_dsa_sched.md
Name: xocc_dsa_sched

Overview:
- DSA-side scheduler that shares one accelerator engine among NUM_Q XOCC command/response queue pairs.
- Pops commands from per-queue first-word-fall-through command FIFOs in round-robin order and issues each to the engine over a valid/ready handshake.
- Waits for the engine's response, with a timeout, and pushes the 32-bit result into the originating queue's response FIFO.
- Sits in the dsa_clk domain between the IU XOCC queue bank and a single shared DSA.

Parameters:
- NUM_Q, 2, number of queue pairs served (1..16).
- CMD_W, 96, command width. Narrower queues are zero-extended at the MSBs.
- RSP_W, 32, response width.
- TIMEOUT, 1024, maximum cycles to wait for a response. 0 disables the timeout.
- TIMEOUT_CODE, 32'hDEAD_0000, response word written when a timeout occurs.

Ports:
- dsa_clk  in  1  clock.
- dsa_rst  in  1  synchronous active-high reset.
- q_en  in  NUM_Q  per-queue scheduling enable.
- empty_cmd  in  NUM_Q  command FIFO empty flags.
- dsa_cmd_buffer  in  NUM_Q*CMD_W  FWFT heads; lane i is bits [i*CMD_W +: CMD_W].
- rd_en_cmd  out  NUM_Q  command pop strobes.
- full_rsp  in  NUM_Q  response FIFO full flags.
- wr_en_rsp  out  NUM_Q  response push strobes.
- dsa_rsp_buffer  out  NUM_Q*RSP_W  response data; lane i is bits [i*RSP_W +: RSP_W].
- eng_req_vld  out  1  command valid to engine.
- eng_req_rdy  in  1  engine accepts the command.
- eng_req_cmd  out  CMD_W  command to engine.
- eng_req_qid  out  4  originating queue id.
- eng_rsp_vld  in  1  engine response strobe.
- eng_rsp_data  in  RSP_W  engine response data.
- busy  out  1  FSM not in IDLE.
- err_timeout  out  1  sticky timeout flag.
- err_clr  in  1  clears err_timeout.

Behaviour:
- Clocking: single clock, dsa_clk. dsa_rst is synchronous and active-high. All state updates on the rising edge of dsa_clk.
- Reset values:
  - State = IDLE; rr_ptr = NUM_Q-1, so queue 0 has first priority.
  - All outputs 0: rd_en_cmd, wr_en_rsp, dsa_rsp_buffer, eng_req_vld, eng_req_cmd, eng_req_qid, busy, err_timeout.
- Eligible request vector: req = ~empty_cmd & q_en.
- IDLE:
  - If req != 0, grant the first set bit searching upward from rr_ptr+1 (mod NUM_Q).
  - In the same cycle: rd_en_cmd[grant] = 1 for exactly one cycle, latch cmd_reg = dsa_cmd_buffer lane[grant], latch qid = grant, set rr_ptr = grant, move to ISSUE.
  - If req == 0, stay in IDLE.
- ISSUE:
  - eng_req_vld = 1, with eng_req_cmd = cmd_reg and eng_req_qid = qid held stable.
  - On eng_req_vld & eng_req_rdy, move to WAIT_RSP and clear timer to 0.
- WAIT_RSP:
  - Timer increments each cycle.
  - eng_rsp_vld latches rsp_reg = eng_rsp_data and moves to WRITE.
  - Otherwise, if TIMEOUT != 0 and timer == TIMEOUT-1: rsp_reg = TIMEOUT_CODE, err_timeout <= 1, move to WRITE.
  - If eng_rsp_vld arrives in the same cycle the timeout fires, the real response wins and the error flag is not set.
  - eng_rsp_vld in any state other than WAIT_RSP is ignored.
- WRITE:
  - dsa_rsp_buffer lane[qid] = rsp_reg; all other lanes are 0.
  - If full_rsp[qid] == 0: wr_en_rsp[qid] = 1 for one cycle, then go to IDLE.
  - If full_rsp[qid] == 1: hold in WRITE with data stable and no strobe until space is available.
- Fixed minimum latency: command pop to engine request is 1 cycle. Engine response to response push is 1 cycle when the FIFO is not full.
- Only one command is in flight, so rd_en_cmd and wr_en_rsp are never both asserted in the same cycle.
- Clearing q_en[i] only affects future arbitration. A command already in flight completes normally.
- err_timeout:
  - Cleared by err_clr.
  - A timeout that fires in the same cycle as err_clr takes priority and sets the flag.
- Reset mid-operation: any state returns to IDLE on the next edge. An in-flight command and its response are dropped, with no push.
- busy = (state != IDLE).

Test Plan:
- Reset, then q_en=2'b11, queue 0 holds 96'h1, engine has rdy=1 and responds 3 cycles after issue with 32'hA5 -> rd_en_cmd=2'b01 for one cycle; eng_req_vld for one cycle with qid=0; wr_en_rsp=2'b01 with lane 0 = 32'hA5.
- Both queues hold 3 commands each and the engine echoes cmd[31:0] -> grants alternate 0,1,0,1,0,1; each wr_en_rsp bit goes to the matching queue.
- eng_req_rdy held low for 5 cycles -> eng_req_vld stays high with a stable cmd and no timer advance; issue completes on the first rdy cycle.
- TIMEOUT=16 and the engine never responds -> on the 16th WAIT_RSP cycle, lane qid = 32'hDEAD_0000 is pushed and err_timeout=1; pulsing err_clr clears it.
- full_rsp[1]=1 for 4 cycles during WRITE for queue 1 -> no wr_en_rsp while full; push occurs in the cycle after full drops, with data unchanged.
- Assert dsa_rst while in WAIT_RSP -> next cycle state=IDLE and all outputs 0; a late eng_rsp_vld causes no push.
